// File: rtl/icache_refill_ctrl_pkg.sv
// Types and constants for the I-cache line refill sequencer.
// Shared by the controller, its victim selector and its bus interface.
package icache_refill_ctrl_pkg;
  localparam int ICACHE_LINE_WORDS = 4;
  localparam int ICACHE_SETS = 2;
  localparam int WORD_OFS_BITS = $clog2(ICACHE_LINE_WORDS);
  localparam int SET_BITS = $clog2(ICACHE_SETS);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WRITE,
    DONE,
    INVAL
  } refill_state_e;
endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Instruction memory read port: request/address out, ack/data back.
// The refill controller is the master, the memory bus the slave.
interface icache_refill_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  o_mem_req;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic                  i_mem_ack;
  logic [DATA_WIDTH-1:0] i_mem_data;

  modport master (
    output o_mem_req,
    output o_mem_addr,
    input  i_mem_ack,
    input  i_mem_data
  );

  modport slave (
    input  o_mem_req,
    input  o_mem_addr,
    output i_mem_ack,
    output i_mem_data
  );
endinterface

// File: rtl/icache_refill_ctrl_victim_sel.sv
// Round-robin victim set pointer; advances once per committed line.
// Wraps SETS-1 -> 0, so any power-of-two set count drops in.
module icache_victim_sel
  import icache_refill_ctrl_pkg::*;
#(
  parameter int SETS = ICACHE_SETS,
  localparam int SW = $clog2(SETS)
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_advance,
  output logic [SW-1:0] o_set
);
  logic [SW-1:0] ptr_q;
  logic [SW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (i_advance) begin
      ptr_d = (ptr_q == SW'(SETS - 1)) ? '0 : ptr_q + SW'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign o_set = ptr_q;
endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache line refill sequencer: REQ/WRITE per word, tag commit, abort.
// ICACHE_CRITICAL_WORD_FIRST_EN: start at the missed word, forward it.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = ICACHE_LINE_WORDS,
  parameter int SETS = ICACHE_SETS,
  localparam int OB = $clog2(LINE_WORDS),
  localparam int SB = $clog2(SETS)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_miss,
  input  logic [ADDR_WIDTH-1:0] i_miss_addr,
  input  logic                  i_abort,
  output logic                  o_busy,
  output logic                  o_done,
  icache_refill_ctrl_if.master  bus,
  output logic                  o_cache_wr,
  output logic                  o_cache_tag_wr,
  output logic                  o_cache_inv,
  output logic [SB-1:0]         o_cache_set,
  output logic [ADDR_WIDTH-1:0] o_cache_addr,
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  output logic                  o_fwd_valid,
  output logic [DATA_WIDTH-1:0] o_fwd_inst,
`endif
  output logic [DATA_WIDTH-1:0] o_cache_data
);
  refill_state_e state_q, state_d;
  logic [OB-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [SB-1:0] set_q, set_d;
  logic abt_q, abt_d;
  logic busy_q, busy_d, done_q, done_d;
  logic req_q, req_d, wr_q, wr_d;
  logic tag_q, tag_d, inv_q, inv_d;
  logic [SB-1:0] cset_q, cset_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [ADDR_WIDTH-1:0] caddr_q, caddr_d;
  logic [DATA_WIDTH-1:0] cdata_q, cdata_d;
  logic [ADDR_WIDTH-1:0] word_a;
  logic [OB-1:0] miss_ofs, last_idx;
  logic [SB-1:0] victim;
  logic unused_bits;

  assign miss_ofs = i_miss_addr[OB+1:2];

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  logic [OB-1:0] start_q, start_d;
  logic fwd_v_q, fwd_v_d;
  logic [DATA_WIDTH-1:0] fwd_i_q, fwd_i_d;
  assign last_idx = start_q - OB'(1);
  assign unused_bits = ^i_miss_addr[1:0];
`else
  assign last_idx = OB'(LINE_WORDS - 1);
  assign unused_bits = ^{i_miss_addr[1:0], miss_ofs};
`endif

  icache_victim_sel #(
    .SETS(SETS)
  ) u_victim (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_advance(state_q == DONE),
    .o_set    (victim)
  );

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    base_d = base_q;
    set_d = set_q;
    abt_d = abt_q;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    start_d = start_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_miss) begin
          state_d = REQ;
          base_d = {i_miss_addr[ADDR_WIDTH-1:OB+2], {(OB+2){1'b0}}};
          set_d = victim;
          abt_d = 1'b0;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
          start_d = miss_ofs;
          cnt_d = miss_ofs;
`else
          cnt_d = '0;
`endif
        end
      end
      REQ: begin
        // An abort here is remembered until the bus ack drains
        abt_d = abt_q | i_abort;
        if (bus.i_mem_ack) state_d = abt_d ? INVAL : WRITE;
      end
      WRITE: begin
        if (i_abort) begin
          state_d = INVAL;
        end else if (cnt_q == last_idx) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + OB'(1);
          state_d = REQ;
        end
      end
      DONE:    state_d = IDLE;
      INVAL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    word_a = base_d | ADDR_WIDTH'({cnt_d, 2'b00});
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    req_d = (state_d == REQ);
    wr_d = (state_d == WRITE);
    inv_d = (state_d == INVAL);
    tag_d = wr_d && (cnt_d == last_idx);
    maddr_d = req_d ? word_a : '0;
    caddr_d = wr_d ? word_a : (inv_d ? base_d : '0);
    cdata_d = wr_d ? bus.i_mem_data : '0;
    cset_d = (wr_d || inv_d) ? set_d : '0;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    fwd_v_d = wr_d && (cnt_d == start_q);
    fwd_i_d = fwd_v_d ? bus.i_mem_data : '0;
`endif
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      base_q <= '0;
      set_q <= '0;
      abt_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      req_q <= 1'b0;
      wr_q <= 1'b0;
      tag_q <= 1'b0;
      inv_q <= 1'b0;
      cset_q <= '0;
      maddr_q <= '0;
      caddr_q <= '0;
      cdata_q <= '0;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
      start_q <= '0;
      fwd_v_q <= 1'b0;
      fwd_i_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      base_q <= base_d;
      set_q <= set_d;
      abt_q <= abt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      req_q <= req_d;
      wr_q <= wr_d;
      tag_q <= tag_d;
      inv_q <= inv_d;
      cset_q <= cset_d;
      maddr_q <= maddr_d;
      caddr_q <= caddr_d;
      cdata_q <= cdata_d;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
      start_q <= start_d;
      fwd_v_q <= fwd_v_d;
      fwd_i_q <= fwd_i_d;
`endif
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign bus.o_mem_req = req_q;
  assign bus.o_mem_addr = maddr_q;
  assign o_cache_wr = wr_q;
  // A late abort in the last WRITE cycle still vetoes the tag commit
  assign o_cache_tag_wr = tag_q & ~i_abort;
  assign o_cache_inv = inv_q;
  assign o_cache_set = cset_q;
  assign o_cache_addr = caddr_q;
  assign o_cache_data = cdata_q;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  assign o_fwd_valid = fwd_v_q;
  assign o_fwd_inst = fwd_i_q;
`endif
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized bench for icache_refill_ctrl against a line-level model.
// Model: address order, per-word waits, victim rotation, abort rules.
module tb_icache_refill_ctrl;
  localparam int LW = 4;
  localparam int SETS = 2;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          set;
  } ev_t;

  logic        i_clock;
  logic        i_reset;
  logic        i_miss;
  logic [31:0] i_miss_addr;
  logic        i_abort;
  logic        o_busy;
  logic        o_done;
  logic        o_cache_wr;
  logic        o_cache_tag_wr;
  logic        o_cache_inv;
  logic [0:0]  o_cache_set;
  logic [31:0] o_cache_addr;
  logic [31:0] o_cache_data;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  logic        o_fwd_valid;
  logic [31:0] o_fwd_inst;
  logic [31:0] fwd_log[$];
`endif

  icache_refill_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem ();

  icache_refill_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_WORDS(LW), .SETS(SETS)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr), .i_abort(i_abort),
    .o_busy(o_busy), .o_done(o_done), .bus(mem),
    .o_cache_wr(o_cache_wr), .o_cache_tag_wr(o_cache_tag_wr),
    .o_cache_inv(o_cache_inv), .o_cache_set(o_cache_set),
    .o_cache_addr(o_cache_addr),
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    .o_fwd_valid(o_fwd_valid), .o_fwd_inst(o_fwd_inst),
`endif
    .o_cache_data(o_cache_data)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  int exp_victim = 0;
  int fixed_wait = 0;
  bit rand_wait = 0;
  logic [31:0] salt;
  int plan[$];
  int wait_log[$];
  logic [31:0] req_log[$];
  ev_t wr_log[$];
  logic [31:0] tag_log[$];
  ev_t inv_log[$];
  int done_log[$];

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0] ^ 16'h5a3c, ~a[15:0]} ^ salt;
  endfunction

  function automatic logic [31:0] line_base(logic [31:0] a);
    return a & ~32'(LW * 4 - 1);
  endfunction

  function automatic int first_ofs(logic [31:0] a);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    return int'((a >> 2) & 32'(LW - 1));
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] word_addr(logic [31:0] a, int k);
    return line_base(a) + 32'(((first_ofs(a) + k) % LW) * 4);
  endfunction

  initial begin
    i_clock = 0;
    forever #5 i_clock = ~i_clock;
  end

  initial forever begin
    @(posedge i_clock);
    cyc++;
  end

  // Memory responder: per-request wait from plan, fixed or random
  initial begin
    int cur_w;
    int wcnt;
    bit have;
    have = 0; wcnt = 0; cur_w = 0;
    mem.i_mem_ack = 0;
    mem.i_mem_data = 0;
    forever begin
      @(negedge i_clock);
      mem.i_mem_ack = 0;
      mem.i_mem_data = $urandom;
      if (mem.o_mem_req === 1'b1) begin
        if (!have) begin
          if (plan.size() > 0) cur_w = plan.pop_front();
          else if (rand_wait) cur_w = $urandom_range(0, 3);
          else cur_w = fixed_wait;
          wait_log.push_back(cur_w);
          have = 1;
          wcnt = 0;
        end
        if (wcnt == cur_w) begin
          mem.i_mem_ack = 1;
          mem.i_mem_data = mem_word(mem.o_mem_addr);
          have = 0;
        end else begin
          wcnt++;
        end
      end else begin
        have = 0;
      end
    end
  end

  initial begin
    ev_t e;
    forever begin
      @(negedge i_clock);
      #2;
      if (mem.o_mem_req === 1'b1) req_log.push_back(mem.o_mem_addr);
      if (o_cache_wr === 1'b1) begin
        e.addr = o_cache_addr; e.data = o_cache_data;
        e.set = int'(o_cache_set);
        wr_log.push_back(e);
      end
      if (o_cache_tag_wr === 1'b1) tag_log.push_back(o_cache_addr);
      if (o_cache_inv === 1'b1) begin
        e.addr = o_cache_addr; e.data = 0;
        e.set = int'(o_cache_set);
        inv_log.push_back(e);
      end
      if (o_done === 1'b1) done_log.push_back(cyc);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
      if (o_fwd_valid === 1'b1) fwd_log.push_back(o_fwd_inst);
`endif
    end
  end

  task automatic clear_logs();
    plan.delete(); wait_log.delete(); req_log.delete();
    wr_log.delete(); tag_log.delete(); inv_log.delete();
    done_log.delete();
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    fwd_log.delete();
`endif
  endtask

  task automatic start_miss(input logic [31:0] a);
    i_miss = 1;
    i_miss_addr = a;
    t0 = cyc;
    @(negedge i_clock);
    i_miss = 0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int c = 0; c < 300; c++) begin
      if (o_busy === 1'b0) begin
        ok = 1;
        return;
      end
      @(negedge i_clock);
    end
  endtask

  task automatic test_reset();
    i_reset = 0; i_miss = 0; i_abort = 0; i_miss_addr = 0;
    repeat (3) @(negedge i_clock);
    total++;
    if ({o_busy, o_done, mem.o_mem_req, o_cache_wr,
         o_cache_tag_wr, o_cache_inv} !== 6'b0) begin
      bad++;
      $display("FAIL reset_strobes got=%b exp=000000",
        {o_busy, o_done, mem.o_mem_req, o_cache_wr,
         o_cache_tag_wr, o_cache_inv});
    end
    total++;
    if ({mem.o_mem_addr, o_cache_addr, o_cache_data, o_cache_set} !== '0) begin
      bad++;
      $display("FAIL reset_buses got=%h/%h/%h/%h exp=0",
        mem.o_mem_addr, o_cache_addr, o_cache_data, o_cache_set);
    end
    i_reset = 1;
    exp_victim = 0;
    @(negedge i_clock);
    total++;
    if (o_busy !== 1'b0) begin
      bad++; $display("FAIL reset_idle busy got=%b exp=0", o_busy);
    end
  endtask

  // w < 0 selects random per-word waits
  task automatic test_refill(input logic [31:0] a, input int w, input string nm);
    bit ok;
    int sum;
    int idx;
    logic [31:0] exp_a;
    clear_logs();
    fixed_wait = (w < 0) ? 0 : w;
    rand_wait = (w < 0);
    start_miss(a);
    total++;
    if (o_busy !== 1'b1) begin
      bad++; $display("FAIL %s busy_rise got=%b exp=1", nm, o_busy);
    end
    wait_idle(ok);
    rand_wait = 0;
    total++;
    if (!ok) begin bad++; $display("FAIL %s timeout got=busy exp=idle", nm); end
    total++;
    if (wait_log.size() != LW) begin
      bad++; $display("FAIL %s req_count got=%0d exp=%0d", nm, wait_log.size(), LW);
    end else begin
      sum = 0; idx = 0;
      foreach (wait_log[k]) begin
        sum += wait_log[k];
        for (int r = 0; r <= wait_log[k]; r++) begin
          total++;
          if (idx >= req_log.size() || req_log[idx] !== word_addr(a, k)) begin
            bad++;
            $display("FAIL %s req[%0d] got=%h exp=%h", nm, idx,
              (idx < req_log.size()) ? req_log[idx] : 32'hx, word_addr(a, k));
          end
          idx++;
        end
      end
      total++;
      if (req_log.size() != idx) begin
        bad++; $display("FAIL %s req_cycles got=%0d exp=%0d", nm, req_log.size(), idx);
      end
      total++;
      if (done_log.size() != 1 || done_log[0] != t0 + 2 * LW + 1 + sum) begin
        bad++;
        $display("FAIL %s done_cycle got=%0d (n=%0d) exp=%0d", nm,
          (done_log.size() > 0) ? done_log[0] - t0 : -1, done_log.size(),
          2 * LW + 1 + sum);
      end
    end
    total++;
    if (wr_log.size() != LW) begin
      bad++; $display("FAIL %s wr_count got=%0d exp=%0d", nm, wr_log.size(), LW);
    end else begin
      foreach (wr_log[k]) begin
        exp_a = word_addr(a, k);
        total++;
        if (wr_log[k].addr !== exp_a || wr_log[k].data !== mem_word(exp_a)
            || wr_log[k].set != exp_victim) begin
          bad++;
          $display("FAIL %s wr[%0d] got=%h/%h/s%0d exp=%h/%h/s%0d", nm, k,
            wr_log[k].addr, wr_log[k].data, wr_log[k].set,
            exp_a, mem_word(exp_a), exp_victim);
        end
      end
    end
    total++;
    if (tag_log.size() != 1 || tag_log[0] !== word_addr(a, LW - 1)) begin
      bad++;
      $display("FAIL %s tag_wr got_n=%0d exp_n=1 exp_addr=%h", nm,
        tag_log.size(), word_addr(a, LW - 1));
    end
    total++;
    if (inv_log.size() != 0) begin
      bad++; $display("FAIL %s inv got=%0d exp=0", nm, inv_log.size());
    end
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    total++;
    if (fwd_log.size() != 1 || fwd_log[0] !== mem_word(word_addr(a, 0))) begin
      bad++;
      $display("FAIL %s fwd got_n=%0d exp=%h", nm, fwd_log.size(),
        mem_word(word_addr(a, 0)));
    end
`endif
    exp_victim = (exp_victim + 1) % SETS;
  endtask

  task automatic test_abort();
    logic [31:0] a;
    logic [31:0] exp_req[$];
    bit seen;
    bit ok;
    a = 32'h0000_1238;
    seen = 0;
    clear_logs();
    fixed_wait = 0; rand_wait = 0;
    plan.push_back(0); plan.push_back(0); plan.push_back(2);
    start_miss(a);
    for (int c = 0; c < 100 && !seen; c++) begin
      if (mem.o_mem_req === 1'b1 && mem.o_mem_addr === word_addr(a, 2)) begin
        i_abort = 1;
        seen = 1;
      end
      @(negedge i_clock);
      i_abort = 0;
    end
    wait_idle(ok);
    total++;
    if (!seen || !ok) begin
      bad++; $display("FAIL abort_req timeout got=%b%b exp=11", seen, ok);
    end
    exp_req = '{word_addr(a, 0), word_addr(a, 1),
                word_addr(a, 2), word_addr(a, 2), word_addr(a, 2)};
    total++;
    if (req_log != exp_req) begin
      bad++; $display("FAIL abort_req_hold got=%p exp=%p", req_log, exp_req);
    end
    total++;
    if (wr_log.size() != 2 || wr_log[0].addr !== word_addr(a, 0)
        || wr_log[1].addr !== word_addr(a, 1)) begin
      bad++; $display("FAIL abort_wr got_n=%0d exp_n=2", wr_log.size());
    end
    total++;
    if (inv_log.size() != 1 || inv_log[0].addr !== line_base(a)
        || inv_log[0].set != exp_victim) begin
      bad++;
      $display("FAIL abort_inv got_n=%0d exp=%h/s%0d", inv_log.size(),
        line_base(a), exp_victim);
    end
    total++;
    if (done_log.size() != 0 || tag_log.size() != 0) begin
      bad++;
      $display("FAIL abort_no_done got=%0d/%0d exp=0/0",
        done_log.size(), tag_log.size());
    end
  endtask

  task automatic test_rotation();
    logic [31:0] a[3];
    logic [31:0] ea;
    int v0;
    bit ok;
    clear_logs();
    rand_wait = 1;
    v0 = exp_victim;
    for (int i = 0; i < 3; i++) begin
      a[i] = $urandom;
      start_miss(a[i]);
      @(negedge i_clock);
      i_miss = 1;
      i_miss_addr = ~a[i];
      @(negedge i_clock);
      i_miss = 0;
      ok = 0;
      for (int c = 0; c < 200; c++) begin
        i_abort = o_done;
        if (o_busy === 1'b0) begin ok = 1; break; end
        @(negedge i_clock);
      end
      i_abort = 0;
      total++;
      if (!ok) begin bad++; $display("FAIL rot_timeout[%0d] got=busy exp=idle", i); end
    end
    rand_wait = 0;
    total++;
    if (done_log.size() != 3) begin
      bad++; $display("FAIL rot_done got=%0d exp=3", done_log.size());
    end
    total++;
    if (wr_log.size() != 3 * LW) begin
      bad++; $display("FAIL rot_wr_count got=%0d exp=%0d", wr_log.size(), 3 * LW);
    end else begin
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < LW; k++) begin
          ea = word_addr(a[i], k);
          total++;
          if (wr_log[i * LW + k].addr !== ea || wr_log[i * LW + k].data !== mem_word(ea)
              || wr_log[i * LW + k].set != (v0 + i) % SETS) begin
            bad++;
            $display("FAIL rot_wr[%0d][%0d] got=%h/s%0d exp=%h/s%0d", i, k,
              wr_log[i * LW + k].addr, wr_log[i * LW + k].set, ea, (v0 + i) % SETS);
          end
        end
      end
    end
    exp_victim = (v0 + 3) % SETS;
  endtask

  task automatic test_abort_last();
    logic [31:0] a;
    bit seen;
    bit ok;
    a = $urandom;
    seen = 0;
    clear_logs();
    fixed_wait = 0; rand_wait = 0;
    i_abort = 1;
    start_miss(a);
    i_abort = 0;
    for (int c = 0; c < 100; c++) begin
      if (o_cache_wr === 1'b1 && o_cache_addr === word_addr(a, LW - 1)) begin
        i_abort = 1;
        seen = 1;
        @(negedge i_clock);
        i_abort = 0;
        break;
      end
      @(negedge i_clock);
    end
    wait_idle(ok);
    total++;
    if (!seen || !ok) begin
      bad++; $display("FAIL abort_last timeout got=%b%b exp=11", seen, ok);
    end
    total++;
    if (wr_log.size() != LW) begin
      bad++; $display("FAIL abort_last_wr got=%0d exp=%0d", wr_log.size(), LW);
    end
    total++;
    if (tag_log.size() != 0) begin
      bad++; $display("FAIL abort_last_tag got=%0d exp=0", tag_log.size());
    end
    total++;
    if (inv_log.size() != 1 || inv_log[0].addr !== line_base(a)
        || inv_log[0].set != exp_victim || done_log.size() != 0) begin
      bad++;
      $display("FAIL abort_last_inv got_n=%0d done_n=%0d exp=%h/s%0d",
        inv_log.size(), done_log.size(), line_base(a), exp_victim);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a;
    bit seen;
    if (exp_victim == 0) test_refill($urandom, 0, "pre_reset");
    a = $urandom;
    seen = 0;
    clear_logs();
    start_miss(a);
    for (int c = 0; c < 100; c++) begin
      if (o_cache_wr === 1'b1) begin seen = 1; break; end
      @(negedge i_clock);
    end
    i_reset = 0;
    @(negedge i_clock);
    total++;
    if (!seen || {o_busy, o_done, mem.o_mem_req, o_cache_wr,
                  o_cache_tag_wr, o_cache_inv} !== 6'b0) begin
      bad++;
      $display("FAIL reset_mid_strobes seen=%b got=%b exp=000000", seen,
        {o_busy, o_done, mem.o_mem_req, o_cache_wr, o_cache_tag_wr, o_cache_inv});
    end
    total++;
    if ({mem.o_mem_addr, o_cache_addr, o_cache_data, o_cache_set} !== '0) begin
      bad++;
      $display("FAIL reset_mid_buses got=%h/%h/%h/%h exp=0",
        mem.o_mem_addr, o_cache_addr, o_cache_data, o_cache_set);
    end
    i_reset = 1;
    exp_victim = 0;
    repeat (2) @(negedge i_clock);
    total++;
    if (o_busy !== 1'b0 || inv_log.size() != 0) begin
      bad++;
      $display("FAIL reset_mid_idle busy=%b inv_n=%0d exp=0/0", o_busy, inv_log.size());
    end
  endtask

  initial begin
    salt = $urandom;
    i_reset = 0; i_miss = 0; i_abort = 0; i_miss_addr = 0;
    test_reset();
    test_refill(32'h0000_1238, 0, "basic");
    test_refill(32'h0000_1238, 3, "wait3");
    test_abort();
    test_refill($urandom, -1, "after_abort");
    test_rotation();
    test_abort_last();
    test_reset_mid();
    test_refill($urandom, -1, "after_reset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
